cordic_sincos: RTL and testbench

Iterative CORDIC rotation engine. Takes a 32-bit binary angle and returns both cosine and sine in Q2.30. It sits directly downstream of the udm CSR decoder: an angle-register write produces one input transfer, and the CSR read path consumes the result. Both sides use valid/ready handshakes, so the CSR logic never samples a stale or in-flight result.

---
 rtl/cordic_sincos.sv | 227 ++++++++++++++++++++++
 tb/tb_cordic_sincos.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_sincos.sv
// -----------------------------------------------------------------------------
// cordic_sincos
//
// Iterative CORDIC rotation engine: one 32-bit binary angle in, cosine and sine
// out in signed Q2.30. It performs one micro-rotation per clock and has a
// valid/ready handshake on each side.
//
// Ports
//   clk_i        system clock
//   rst_n_i      asynchronous active-low reset
//   in_valid_i   angle_bi carries a valid angle
//   in_ready_o   block accepts an angle this cycle (IDLE only, 0 during reset)
//   angle_bi     binary angle, 2^32 = one full turn, 0x40000000 = 90 degrees
//   out_valid_o  cos_bo / sin_bo hold a finished result
//   out_ready_i  consumer takes the result this cycle
//   cos_bo       cosine, signed Q2.30, saturated to [0x80000001, 0x7FFFFFFF]
//   sin_bo       sine,   signed Q2.30, saturated to [0x80000001, 0x7FFFFFFF]
//
// Parameter
//   ITER         number of micro-rotations, legal range 8..30
// -----------------------------------------------------------------------------
module cordic_sincos #(
  parameter int ITER = 24
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] angle_bi,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] cos_bo,
  output logic [31:0] sin_bo
);

  typedef enum logic [1:0] {
    IDLE,
    ROT,
    DONE
  } state_t;

  // Index of the final micro-rotation.
  localparam logic [4:0] LAST_IDX = 5'(ITER - 1);

  // CORDIC gain compensation K = 0.6072529350 in Q2.30. The x/y registers
  // carry two extra fraction bits (Q2.32) so the truncating shifts lose less.
  localparam logic [31:0] K_Q30 = 32'h26DD3B6A;
  localparam logic signed [33:0] X_INIT = $signed({K_Q30, 2'b00});

  state_t state_q, state_d;

  logic signed [33:0] x_q, y_q;
  logic signed [32:0] z_q;
  logic [4:0]         cnt_q;
  logic               neg_q;
  logic               last_q;    // final micro-rotation has been applied

  logic               in_fire;
  logic               fold_neg;
  logic [31:0]        fold;
  logic [31:0]        atan_val;
  logic signed [32:0] a_ext;
  logic signed [33:0] x_sh, y_sh;
  logic signed [33:0] x_rot, y_rot;
  logic signed [32:0] z_rot;

  // Ready is decoded from state; during reset the state register already reads
  // IDLE, so the reset input is folded in to keep the producer stalled.
  assign in_ready_o = (state_q == IDLE) && rst_n_i;
  assign in_fire    = in_valid_i && in_ready_o;

  // Quadrant fold: angles in the second and third quadrant are rotated by 180
  // degrees and the result negated, so z always starts within +/-90 degrees.
  assign fold_neg = angle_bi[31] ^ angle_bi[30];
  assign fold     = fold_neg ? (angle_bi ^ 32'h8000_0000) : angle_bi;

  // Arctangent ROM: A[i] = round(atan(2^-i) * 2^31 / pi).
  always_comb begin
    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the case statement can leave it unassigned and infer a latch.
    atan_val = '0;
    case (cnt_q)
      5'd0:  atan_val = 32'h2000_0000;
      5'd1:  atan_val = 32'h12E4_051E;
      5'd2:  atan_val = 32'h09FB_385B;
      5'd3:  atan_val = 32'h0511_11D4;
      5'd4:  atan_val = 32'h028B_0D43;
      5'd5:  atan_val = 32'h0145_D7E1;
      5'd6:  atan_val = 32'h00A2_F61E;
      5'd7:  atan_val = 32'h0051_7C55;
      5'd8:  atan_val = 32'h0028_BE53;
      5'd9:  atan_val = 32'h0014_5F2F;
      5'd10: atan_val = 32'h000A_2F98;
      5'd11: atan_val = 32'h0005_17CC;
      5'd12: atan_val = 32'h0002_8BE6;
      5'd13: atan_val = 32'h0001_45F3;
      5'd14: atan_val = 32'h0000_A2FA;
      5'd15: atan_val = 32'h0000_517D;
      5'd16: atan_val = 32'h0000_28BE;
      5'd17: atan_val = 32'h0000_145F;
      5'd18: atan_val = 32'h0000_0A30;
      5'd19: atan_val = 32'h0000_0518;
      5'd20: atan_val = 32'h0000_028C;
      5'd21: atan_val = 32'h0000_0146;
      5'd22: atan_val = 32'h0000_00A3;
      5'd23: atan_val = 32'h0000_0051;
      5'd24: atan_val = 32'h0000_0029;
      5'd25: atan_val = 32'h0000_0014;
      5'd26: atan_val = 32'h0000_000A;
      5'd27: atan_val = 32'h0000_0005;
      5'd28: atan_val = 32'h0000_0003;
      5'd29: atan_val = 32'h0000_0001;
      default: atan_val = '0;
    endcase
  end

  assign a_ext = $signed({1'b0, atan_val});

  // One micro-rotation; the direction follows the sign of the residual angle.
  assign x_sh = x_q >>> cnt_q;
  assign y_sh = y_q >>> cnt_q;

  always_comb begin
    if (z_q[32]) begin
      x_rot = x_q + y_sh;
      y_rot = y_q - x_sh;
      z_rot = z_q + a_ext;
    end else begin
      x_rot = x_q - y_sh;
      y_rot = y_q + x_sh;
      z_rot = z_q - a_ext;
    end
  end

  // Apply the quadrant negation, drop the two guard bits with rounding and
  // clamp symmetrically so the result never reads as -2.0.
  function automatic logic [31:0] to_out(input logic signed [33:0] v,
                                         input logic neg);
    logic signed [34:0] s;
    logic signed [34:0] r;
    s = neg ? -$signed({v[33], v}) : $signed({v[33], v});
    r = (s + 35'sd2) >>> 2;
    if (r > 35'sd2147483647) begin
      return 32'h7FFF_FFFF;
    end else if (r < -35'sd2147483647) begin
      return 32'h8000_0001;
    end else begin
      return r[31:0];
    end
  endfunction

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: sequential blocks use non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop regardless of order.
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_fire)     state_d = ROT;
      ROT:  if (last_q)      state_d = DONE;
      DONE: if (out_ready_i) state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // NOTE: the rotation registers are reset along with the control flops so
      // no X can ever propagate through the adders into the outputs.
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      last_q      <= 1'b0;
      out_valid_o <= 1'b0;
      cos_bo      <= '0;
      sin_bo      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_fire) begin
            x_q    <= X_INIT;
            y_q    <= '0;
            z_q    <= $signed({fold[31], fold});
            neg_q  <= fold_neg;
            cnt_q  <= '0;
            last_q <= 1'b0;
          end
        end
        ROT: begin
          if (!last_q) begin
            x_q <= x_rot;
            y_q <= y_rot;
            z_q <= z_rot;
            // The counter parks on the last index instead of wrapping.
            if (cnt_q == LAST_IDX) begin
              last_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end else begin
            cos_bo      <= to_out(x_q, neg_q);
            sin_bo      <= to_out(y_q, neg_q);
            out_valid_o <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
          end
        end
        default: out_valid_o <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_sincos.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_cordic_sincos
//
// Self-checking bench for cordic_sincos. Results are compared with a real-number
// model that decomposes the folded angle into the arctangent micro-rotations
// chosen by the sign of the residual angle and evaluates cos/sin of that
// rotation in double precision, and with the ideal values of the angle itself.
// -----------------------------------------------------------------------------
module tb_cordic_sincos;

  localparam int ITER      = 24;
  localparam int LAT       = ITER + 1;
  localparam int BOUND     = 200;
  localparam int TOL_MODEL = 16;
  // Against the ideal value: residual angle after the last micro-rotation
  // (up to ~128 LSB) plus table rounding and fixed-point truncation.
  localparam int TOL_IDEAL = 160;
  localparam int N_RANDOM  = 1000;
  localparam real PI       = 3.14159265358979323846;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        out_ready_i = 1'b0;
  logic [31:0] angle_bi = '0;
  logic        in_ready_o;
  logic        out_valid_o;
  logic [31:0] cos_bo;
  logic [31:0] sin_bo;

  int checks = 0;
  int failures = 0;
  int n_in = 0;
  int n_out = 0;

  always #5 clk_i = ~clk_i;

  cordic_sincos #(.ITER(ITER)) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .angle_bi   (angle_bi),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .cos_bo     (cos_bo),
    .sin_bo     (sin_bo)
  );

  // Transfer counters.
  always @(posedge clk_i) begin
    if (in_valid_i && in_ready_o) n_in <= n_in + 1;
    if (out_valid_o && out_ready_i) n_out <= n_out + 1;
  end

  // ---------------------------------------------------------------- model
  function automatic int to_q30(input real v);
    longint r;
    r = longint'(v * 1073741824.0);
    if (r > 64'sd2147483647) r = 64'sd2147483647;
    if (r < -64'sd2147483647) r = -64'sd2147483647;
    return int'(r);
  endfunction

  function automatic void model(input logic [31:0] ang, output int c, output int s);
    logic [31:0] f;
    bit          neg;
    longint      z;
    longint      a;
    real         t, theta, gain, rc, rs;
    neg   = ang[31] ^ ang[30];
    f     = neg ? (ang ^ 32'h8000_0000) : ang;
    z     = longint'($signed(f));
    theta = 0.0;
    gain  = real'(32'h26DD3B6A) / 1073741824.0;
    for (int i = 0; i < ITER; i++) begin
      t = $atan(1.0 / (2.0 ** i));
      a = longint'($floor(t * 2147483648.0 / PI + 0.5));
      if (z >= 0) begin
        theta = theta + t;
        z     = z - a;
      end else begin
        theta = theta - t;
        z     = z + a;
      end
      gain = gain * $sqrt(1.0 + 1.0 / (4.0 ** i));
    end
    rc = gain * $cos(theta);
    rs = gain * $sin(theta);
    if (neg) begin
      rc = -rc;
      rs = -rs;
    end
    c = to_q30(rc);
    s = to_q30(rs);
  endfunction

  function automatic bit in_tol(input int a, input int b, input int tol);
    longint d;
    d = longint'(a) - longint'(b);
    if (d < 0) d = -d;
    return d <= longint'(tol);
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic send(input logic [31:0] ang, output bit ok);
    ok = 1'b0;
    @(negedge clk_i);
    angle_bi   = ang;
    in_valid_i = 1'b1;
    for (int k = 0; k < BOUND; k++) begin
      if (in_ready_o) begin
        @(posedge clk_i);
        ok = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    #1;
    in_valid_i = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output bit ok);
    ok  = 1'b0;
    lat = 0;
    for (int k = 0; k < BOUND; k++) begin
      @(posedge clk_i);
      #1;
      lat++;
      if (out_valid_o) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic take();
    @(negedge clk_i);
    out_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    out_ready_i = 1'b0;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if (in_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_ready_held: got %b expected 0", in_ready_o);
    end
    checks++;
    if (out_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid: got %b expected 0", out_valid_o);
    end
    checks++;
    if (cos_bo !== 32'h0 || sin_bo !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: got cos=%h sin=%h expected 0/0", cos_bo, sin_bo);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    checks++;
    if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got ready=%b valid=%b expected 1/0", in_ready_o, out_valid_o);
    end
  endtask

  task automatic test_directed();
    logic [31:0] angs [6];
    logic [31:0] ec   [6];
    logic [31:0] es   [6];
    int mc, ms, lat;
    bit ok;
    angs = '{32'h0000_0000, 32'h4000_0000, 32'h8000_0000,
             32'hC000_0000, 32'h2000_0000, 32'hEAAA_AAAB};
    ec   = '{32'h4000_0000, 32'h0000_0000, 32'hC000_0000,
             32'h0000_0000, 32'h2D41_3CCD, 32'h376C_F5D1};
    es   = '{32'h0000_0000, 32'h4000_0000, 32'h0000_0000,
             32'hC000_0000, 32'h2D41_3CCD, 32'hE000_0000};
    for (int i = 0; i < 6; i++) begin
      send(angs[i], ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL directed_accept angle=%h: got no transfer expected one", angs[i]);
        continue;
      end
      wait_valid(lat, ok);
      checks++;
      if (!ok || lat != LAT) begin
        failures++;
        $display("FAIL directed_latency angle=%h: got %0d expected %0d", angs[i], lat, LAT);
      end
      model(angs[i], mc, ms);
      checks++;
      if (!in_tol(int'($signed(cos_bo)), mc, TOL_MODEL) || !in_tol(int'($signed(sin_bo)), ms, TOL_MODEL)) begin
        failures++;
        $display("FAIL directed_model angle=%h: got cos=%h sin=%h expected cos=%h sin=%h",
                 angs[i], cos_bo, sin_bo, mc, ms);
      end
      checks++;
      if (!in_tol(int'($signed(cos_bo)), int'($signed(ec[i])), TOL_IDEAL) ||
          !in_tol(int'($signed(sin_bo)), int'($signed(es[i])), TOL_IDEAL)) begin
        failures++;
        $display("FAIL directed_ideal angle=%h: got cos=%h sin=%h expected cos=%h sin=%h",
                 angs[i], cos_bo, sin_bo, ec[i], es[i]);
      end
      take();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a0, a1, c0, s0;
    int mc, ms, lat;
    bit ok, stable;
    a0 = 32'h1555_5555;
    a1 = 32'hA000_0000;
    out_ready_i = 1'b0;
    send(a0, ok);
    angle_bi   = a1;
    in_valid_i = 1'b1;
    wait_valid(lat, ok);
    checks++;
    if (!ok || lat != LAT) begin
      failures++;
      $display("FAIL bp_latency: got %0d expected %0d", lat, LAT);
    end
    c0 = cos_bo;
    s0 = sin_bo;
    model(a0, mc, ms);
    checks++;
    if (!in_tol(int'($signed(c0)), mc, TOL_MODEL) || !in_tol(int'($signed(s0)), ms, TOL_MODEL)) begin
      failures++;
      $display("FAIL bp_first_result: got cos=%h sin=%h expected cos=%h sin=%h", c0, s0, mc, ms);
    end
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk_i);
      #1;
      if (cos_bo !== c0 || sin_bo !== s0 || in_ready_o !== 1'b0 || out_valid_o !== 1'b1) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      failures++;
      $display("FAIL bp_hold: got cos=%h sin=%h ready=%b valid=%b expected stable %h/%h, 0/1",
               cos_bo, sin_bo, in_ready_o, out_valid_o, c0, s0);
    end
    @(negedge clk_i);
    out_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    out_ready_i = 1'b0;
    checks++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: got valid=%b ready=%b expected 0/1", out_valid_o, in_ready_o);
    end
    checks++;
    if (cos_bo !== c0 || sin_bo !== s0) begin
      failures++;
      $display("FAIL bp_output_hold: got cos=%h sin=%h expected %h/%h", cos_bo, sin_bo, c0, s0);
    end
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    checks++;
    if (in_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL bp_second_accept: got ready=%b expected 0", in_ready_o);
    end
    wait_valid(lat, ok);
    model(a1, mc, ms);
    checks++;
    if (!ok || lat != LAT || !in_tol(int'($signed(cos_bo)), mc, TOL_MODEL) ||
        !in_tol(int'($signed(sin_bo)), ms, TOL_MODEL)) begin
      failures++;
      $display("FAIL bp_second_result: got lat=%0d cos=%h sin=%h expected lat=%0d cos=%h sin=%h",
               lat, cos_bo, sin_bo, LAT, mc, ms);
    end
    take();
  endtask

  task automatic test_busy_reject();
    logic [31:0] a0;
    int mc, ms, lat, in0;
    bit ok, quiet;
    a0  = 32'h0800_0000;
    in0 = n_in;
    send(a0, ok);
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    angle_bi   = 32'h1000_0000;
    in_valid_i = 1'b1;
    checks++;
    if (in_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL busy_ready: got %b expected 0", in_ready_o);
    end
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    wait_valid(lat, ok);
    model(a0, mc, ms);
    checks++;
    if (!ok || lat != LAT - 6 || !in_tol(int'($signed(cos_bo)), mc, TOL_MODEL) ||
        !in_tol(int'($signed(sin_bo)), ms, TOL_MODEL)) begin
      failures++;
      $display("FAIL busy_result: got lat=%0d cos=%h sin=%h expected lat=%0d cos=%h sin=%h",
               lat, cos_bo, sin_bo, LAT - 6, mc, ms);
    end
    take();
    quiet = 1'b1;
    for (int k = 0; k < LAT + 5; k++) begin
      @(posedge clk_i);
      #1;
      if (out_valid_o) quiet = 1'b0;
    end
    checks++;
    if (!quiet || n_in - in0 != 1) begin
      failures++;
      $display("FAIL busy_not_consumed: got transfers=%0d spurious_valid=%b expected 1/0",
               n_in - in0, !quiet);
    end
  endtask

  task automatic test_reset_mid();
    int mc, ms, lat;
    bit ok, quiet;
    send(32'h1234_5678, ok);
    repeat (10) @(posedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b0;
    #1;
    checks++;
    if (out_valid_o !== 1'b0 || cos_bo !== 32'h0 || sin_bo !== 32'h0 || in_ready_o !== 1'b0) begin
      failures++;
      $display("FAIL midreset_clear: got valid=%b cos=%h sin=%h ready=%b expected 0/0/0/0",
               out_valid_o, cos_bo, sin_bo, in_ready_o);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    quiet = 1'b1;
    for (int k = 0; k < LAT + 5; k++) begin
      @(posedge clk_i);
      #1;
      if (out_valid_o) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      failures++;
      $display("FAIL midreset_no_valid: got valid after reset expected none");
    end
    send(32'h0, ok);
    wait_valid(lat, ok);
    model(32'h0, mc, ms);
    checks++;
    if (!ok || lat != LAT || !in_tol(int'($signed(cos_bo)), mc, TOL_MODEL) ||
        !in_tol(int'($signed(sin_bo)), ms, TOL_MODEL)) begin
      failures++;
      $display("FAIL midreset_fresh: got lat=%0d cos=%h sin=%h expected lat=%0d cos=%h sin=%h",
               lat, cos_bo, sin_bo, LAT, mc, ms);
    end
    take();
  endtask

  task automatic test_random();
    logic [31:0] ang, c0, s0;
    int mc, ms, in0, out0;
    bit ok, got, seen, stable;
    in0  = n_in;
    out0 = n_out;
    for (int n = 0; n < N_RANDOM; n++) begin
      ang = $urandom;
      send(ang, ok);
      got = 1'b0;
      seen = 1'b0;
      stable = 1'b1;
      c0 = '0;
      s0 = '0;
      for (int k = 0; k < BOUND && ok; k++) begin
        @(negedge clk_i);
        out_ready_i = ($urandom_range(0, 3) != 0);
        if (out_valid_o) begin
          if (!seen) begin
            seen = 1'b1;
            c0 = cos_bo;
            s0 = sin_bo;
          end else if (cos_bo !== c0 || sin_bo !== s0) begin
            stable = 1'b0;
          end
          if (out_ready_i) begin
            got = 1'b1;
            @(posedge clk_i);
            #1;
            out_ready_i = 1'b0;
            break;
          end
        end
      end
      out_ready_i = 1'b0;
      checks++;
      if (!got || !stable) begin
        failures++;
        $display("FAIL random_handshake angle=%h: got transfer=%b stable=%b expected 1/1", ang, got, stable);
        continue;
      end
      model(ang, mc, ms);
      checks++;
      if (!in_tol(int'($signed(c0)), mc, TOL_MODEL)) begin
        failures++;
        $display("FAIL random_cos angle=%h: got %h expected %h", ang, c0, mc);
      end
      checks++;
      if (!in_tol(int'($signed(s0)), ms, TOL_MODEL)) begin
        failures++;
        $display("FAIL random_sin angle=%h: got %h expected %h", ang, s0, ms);
      end
    end
    checks++;
    if (n_in - in0 != N_RANDOM || n_out - out0 != N_RANDOM) begin
      failures++;
      $display("FAIL random_transfer_count: got in=%0d out=%0d expected %0d/%0d",
               n_in - in0, n_out - out0, N_RANDOM, N_RANDOM);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_busy_reject();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
